i3c_reg_access_arbiter: RTL

Shares the RCD register-file access port between two requesters: the I3C slave controller (port 0) and the internal RCD control/sequencer logic (port 1). It accepts one transaction at a time and arbitrates round-robin. It sequences the register-file req/ack handshake and returns a completion, with read data and an error flag, to the requesting port. It sits between i3c_slave_controller's register interface and the register file.

---
 rtl/i3c_reg_access_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/i3c_reg_access_arbiter.sv
// i3c_reg_access_arbiter: round-robin sharing of the RCD register-file port between the I3C slave (port 0) and internal logic (port 1); optional ack timeout under I3C_ARB_TIMEOUT_EN
module i3c_reg_access_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 256,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack,
    output logic              arb_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t            state;
    logic              last_grant;
    logic              port;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              gnt_illegal;
    logic              timeout;

    // a lone requester wins; a tie goes to the port that was not served last
    always_comb begin
        gnt0         = p0_req_valid && (!p1_req_valid || last_grant);
        gnt1         = p1_req_valid && (!p0_req_valid || !last_grant);
        p0_req_ready = (state == IDLE) && !rst && gnt0;
        p1_req_ready = (state == IDLE) && !rst && gnt1;
        gnt_we       = gnt1 ? p1_req_we : p0_req_we;
        gnt_addr     = gnt1 ? p1_req_addr : p0_req_addr;
        gnt_wdata    = gnt1 ? p1_req_wdata : p0_req_wdata;
        gnt_illegal  = 32'(gnt_addr) >= NUM_REGS;
    end

    assign arb_busy = state != IDLE;

`ifdef I3C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    // ack-wait counter, restarted while idle so every access starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state != ISSUE)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign timeout = (state == ISSUE) && !reg_ack && (cnt == CW'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // accept one transaction, run the register-file handshake, hold the completion until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            port         <= 1'b0;
            reg_req      <= 1'b0;
            reg_we       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt0 || gnt1) begin
                    port       <= gnt1;
                    last_grant <= gnt1;
                    reg_we     <= gnt_we;
                    reg_addr   <= gnt_addr;
                    reg_wdata  <= gnt_wdata;
                    if (gnt_illegal) begin
                        state        <= RESP;
                        rsp_err      <= 1'b1;
                        rsp_rdata    <= '0;
                        p0_rsp_valid <= !gnt1;
                        p1_rsp_valid <= gnt1;
                    end else begin
                        state   <= ISSUE;
                        reg_req <= 1'b1;
                    end
                end
                ISSUE: if (reg_ack || timeout) begin
                    state        <= RESP;
                    reg_req      <= 1'b0;
                    rsp_err      <= !reg_ack;
                    rsp_rdata    <= (reg_ack && !reg_we) ? reg_rdata : '0;
                    p0_rsp_valid <= !port;
                    p1_rsp_valid <= port;
                end
                RESP: if (rsp_ready) begin
                    state        <= IDLE;
                    p0_rsp_valid <= 1'b0;
                    p1_rsp_valid <= 1'b0;
                    rsp_rdata    <= '0;
                    rsp_err      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
